// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
//   Shared definitions for the serial pattern transmitter and the
//   sequence-detector FSMs that consume its stream.
//   - ST_ENC_* : raw state encodings, visible to other blocks
//   - state_t  : transmitter state type built on those encodings
//   Optional feature macro: SEQ_GEN_PARITY_EN (PARITY state is only entered
//   when it is defined; the encoding is always reserved).
// -----------------------------------------------------------------------------
package seq_gen_pkg;

   localparam logic [1:0] ST_ENC_IDLE   = 2'd0;
   localparam logic [1:0] ST_ENC_SHIFT  = 2'd1;
   localparam logic [1:0] ST_ENC_PARITY = 2'd2;
   localparam logic [1:0] ST_ENC_GAP    = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = ST_ENC_IDLE,
      S_SHIFT  = ST_ENC_SHIFT,
      S_PARITY = ST_ENC_PARITY,
      S_GAP    = ST_ENC_GAP
   } state_t;

endpackage

// File: rtl/seq_gen_if.sv
// -----------------------------------------------------------------------------
// seq_gen_if
//   Control and serial-output bundle of the pattern transmitter.
//   master : START, STOP, PATTERN, REPEAT driven; OUT/OUT_VALID/BUSY/DONE seen
//   slave  : the transmitter side (seq_gen)
// -----------------------------------------------------------------------------
interface seq_gen_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4
);
   logic             START;
   logic             STOP;
   logic [PAT_W-1:0] PATTERN;
   logic [CNT_W-1:0] REPEAT;
   logic             OUT;
   logic             OUT_VALID;
   logic             BUSY;
   logic             DONE;

   modport master (
      output START, STOP, PATTERN, REPEAT,
      input  OUT, OUT_VALID, BUSY, DONE
   );

   modport slave (
      input  START, STOP, PATTERN, REPEAT,
      output OUT, OUT_VALID, BUSY, DONE
   );
endinterface

// File: rtl/seq_gen_shifter.sv
// -----------------------------------------------------------------------------
// seq_gen_shifter
//   Pattern register plus bit counter for seq_gen.
//   clk_i, rst_n_i : clock, async active-low reset
//   load_i         : capture pat_i (its MSB is emitted by the caller this edge)
//   shift_i        : advance to the next bit
//   pat_i          : pattern to capture
//   msb_o          : next bit to be emitted
//   last_o         : the bit currently on the line is the pattern's last bit
//   par_o          : even parity of the pattern (SEQ_GEN_PARITY_EN only)
// -----------------------------------------------------------------------------
module seq_gen_shifter #(
   parameter int PAT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [PAT_W-1:0] pat_i,
   output logic             msb_o,
`ifdef SEQ_GEN_PARITY_EN
   output logic             par_o,
`endif
   output logic             last_o
);
   localparam int BW = $clog2(PAT_W);

   // The register rotates rather than shifting in zeros: after PAT_W steps it
   // holds the latched pattern again, so a repeat needs no separate reload
   // path and the parity of the contents always equals the pattern's parity.
   logic [PAT_W-1:0] sh_q;
   logic [BW-1:0]    cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         sh_q  <= {pat_i[PAT_W-2:0], pat_i[PAT_W-1]};
         cnt_q <= '0;
      end else if (shift_i) begin
         sh_q  <= {sh_q[PAT_W-2:0], sh_q[PAT_W-1]};
         cnt_q <= last_o ? '0 : cnt_q + BW'(1);
      end
   end

   assign msb_o  = sh_q[PAT_W-1];
   assign last_o = (cnt_q == BW'(PAT_W - 1));
`ifdef SEQ_GEN_PARITY_EN
   assign par_o  = ^sh_q;
`endif

endmodule

// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen
//   Serial pattern transmitter: sends PATTERN MSB first, REPEAT times
//   (0 counts as 1), with GAP idle cycles between repeats.
//   CLK, RST_N : clock, async active-low reset
//   bus.START/STOP/PATTERN/REPEAT : control inputs
//   bus.OUT/OUT_VALID              : registered serial data and qualifier
//   bus.BUSY/DONE                  : in-progress flag, completion pulse
//   Optional feature macro: SEQ_GEN_PARITY_EN appends an even-parity bit
//   to every frame.
// -----------------------------------------------------------------------------
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4,
   parameter int GAP   = 0
) (
   input logic      CLK,
   input logic      RST_N,
   seq_gen_if.slave bus
);
   localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [GCW-1:0]   gap_q, gap_d;
   logic             out_q, out_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load, shift, frame_end;
   logic             sh_msb, sh_last;
`ifdef SEQ_GEN_PARITY_EN
   logic             sh_par;
`endif

   seq_gen_shifter #(.PAT_W(PAT_W)) u_shifter (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .load_i  (load),
      .shift_i (shift),
      .pat_i   (bus.PATTERN),
      .msb_o   (sh_msb),
`ifdef SEQ_GEN_PARITY_EN
      .par_o   (sh_par),
`endif
      .last_o  (sh_last)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         gap_q   <= '0;
         out_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         gap_q   <= gap_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Output registers are loaded with the value for the cycle that follows
   // this edge, so the first bit appears right after START is accepted and
   // DONE appears in the same cycle the FSM is back in IDLE.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      gap_d     = gap_q;
      out_d     = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      frame_end = 1'b0;

      if (state_q != S_IDLE && bus.STOP) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.START && !bus.STOP) begin
                  load    = 1'b1;
                  rem_d   = (bus.REPEAT == '0) ? CNT_W'(1) : bus.REPEAT;
                  state_d = S_SHIFT;
                  out_d   = bus.PATTERN[PAT_W-1];
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
               end
            end
            S_SHIFT: begin
               if (!sh_last) begin
                  shift   = 1'b1;
                  out_d   = sh_msb;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
               end else begin
`ifdef SEQ_GEN_PARITY_EN
                  state_d = S_PARITY;
                  out_d   = sh_par;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
`else
                  frame_end = 1'b1;
`endif
               end
            end
`ifdef SEQ_GEN_PARITY_EN
            S_PARITY: frame_end = 1'b1;
`endif
            S_GAP: begin
               busy_d = 1'b1;
               if (gap_q == '0) begin
                  state_d = S_SHIFT;
                  shift   = 1'b1;
                  out_d   = sh_msb;
                  valid_d = 1'b1;
               end else begin
                  gap_d = gap_q - GCW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase

         // Last bit (or parity bit) of a frame is on the line this cycle.
         if (frame_end) begin
            if (rem_q != '0) begin
               rem_d = rem_q - CNT_W'(1);
            end
            if (rem_q <= CNT_W'(1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (GAP == 0) begin
               state_d = S_SHIFT;
               shift   = 1'b1;
               out_d   = sh_msb;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end else begin
               state_d = S_GAP;
               gap_d   = GCW'(GAP - 1);
               busy_d  = 1'b1;
            end
         end
      end
   end

   assign bus.OUT       = out_q;
   assign bus.OUT_VALID = valid_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;

endmodule
